vpu_sram_rd_burst_engine: RTL
=============================

// Module: vpu_sram_rd_burst_engine
// PURPOSE
//  Multi-port SRAM read engine between the VPU operand fetch stage and the SRAM read ports.
//  Takes one command that names a bank, base address and burst length for each read port.
//  Runs req/ack arbitration and issues burst read beats (reb/rlast) on every enabled port.
//  Gathers returned rdata, forwards it registered, and pulses done when all ports finish.
// PARAMETERS
//  PORT_CNT    3   number of SRAM read ports (SRAM_R_PORT_CNT)
//  DATA_W      SRAM_DATA_WIDTH       rdata width per port
//  BANK_W      SRAM_BANK_CNT_LG2     bank id width
//  ADDR_W      SRAM_BANK_DEPTH_LG2   bank word address width
//  MAX_BURST   16  max beats per port per command (power of 2); LEN_W=$clog2(MAX_BURST)
// PORTS
//  clk           in   1               single clock, posedge
//  rst           in   1               synchronous, active-high reset
//  cmd_valid     in   1               command present
//  cmd_ready     out  1               engine idle, command accepted when valid&ready
//  cmd_port_en   in   PORT_CNT        per-port enable
//  cmd_rid       in   PORT_CNT*BANK_W per-port bank id
//  cmd_addr      in   PORT_CNT*ADDR_W per-port base address
//  cmd_len       in   LEN_W           burst length minus 1 (common to all ports)
//  req           out  PORT_CNT        bank request
//  ack           in   PORT_CNT        bank grant (level)
//  rid           out  PORT_CNT*BANK_W bank id
//  addr          out  PORT_CNT*ADDR_W beat address
//  reb           out  PORT_CNT        read enable, ACTIVE-LOW, one beat per cycle low
//  rlast         out  PORT_CNT        marks final issued beat
//  rdata         in   PORT_CNT*DATA_W returned data
//  rvalid        in   PORT_CNT        returned data valid
//  dout_valid    out  PORT_CNT        registered rvalid
//  dout_data     out  PORT_CNT*DATA_W registered rdata
//  busy          out  1               command in flight
//  done          out  1               1-cycle pulse, all enabled ports complete
//  err           out  1               sticky: rvalid beyond expected beats; cleared by rst only
// BEHAVIOUR
//  Reset values: cmd_ready=1; req/rlast/dout_valid/busy/done/err=0; reb='1; rid/addr/dout_data=0.
//  Accept (cycle 0): latch en/rid/addr/len, cmd_ready=0, busy=1.
//  Per-port FSM: IDLE->REQ->ISSUE->DRAIN->IDLE.
//   REQ (from cycle 1): req=1, rid driven. Wait for ack=1 (no timeout).
//   ISSUE: req stays 1. For each cycle with ack=1, one beat: reb=0, addr=base+k.
//    Address is mod 2^ADDR_W, so it wraps past max to 0.
//    rlast=1 on beat k=len. If ack=0 in ISSUE: reb=1 and addr held (stall).
//    After the rlast beat: req=0 and go to DRAIN.
//   DRAIN: count rvalid beats; leave when len+1 beats are received.
//  rvalid is accepted in ISSUE and DRAIN (return may overlap issue; latency arbitrary >=1).
//  Beat count is per-port, LEN_W+1 bits.
//  rvalid in IDLE/REQ, or after len+1 beats are received: err=1, data is dropped (no dout_valid).
//  dout_valid/dout_data follow rvalid/rdata with 1-cycle latency. No backpressure.
//  done pulses the cycle after the last enabled port leaves DRAIN.
//   busy=0 and cmd_ready=1 in that same cycle.
//  cmd_port_en==0: no port activity; done pulses cycle 1; cmd_ready=1 cycle 1.
//  cmd_valid while busy: ignored (no queueing).
//  rst mid-burst: all FSMs go to IDLE next cycle; outputs return to reset values.
//   In-flight rvalid after reset sets err only if it arrives after the reset cycle.
// STRUCTURE
//  VPU_PKG: rd_chan_state_t enum {RD_IDLE,RD_REQ,RD_ISSUE,RD_DRAIN}.
//   Also defines MAX_BURST and LEN_W next to the SRAM_* constants.
//  Sub-module vpu_sram_rd_chan: one port FSM with issue/return counters and err flag.
//   Generated PORT_CNT times.
//  Top level: command latch, done/busy aggregation (AND of per-port idle), err OR.
// TESTING
//  T1 port0 only, rid=2, addr=0x10, len=3; ack=1 at cycle 3; rvalid 5 cycles later
//     -> reb low on addrs 0x10..0x13; rlast on 0x13; 4 dout_valid; done one cycle after 4th rvalid.
//  T2 all 3 ports, len=0; acks at cycles 2/4/6
//     -> one beat each with rlast=1; done only after port2 data returns.
//  T3 addr=2^ADDR_W-2, len=3
//     -> beat addresses max-1, max, 0, 1.
//  T4 ack drops for 2 cycles after beat 1, len=5
//     -> reb=1 and addr held for those 2 cycles; 6 beats total, no duplicate address.
//  T5 extra rvalid after the last beat; also rvalid while idle
//     -> err=1 sticky, no dout_valid, done unaffected.
//  T6 rst=1 mid-ISSUE, then new command
//     -> req=0, reb='1 next cycle; cmd_ready=1; second command completes normally.

Source files
------------

// File: rtl/vpu_sram_rd_burst_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vpu_sram_rd_burst_engine_pkg
// Purpose  : Shared SRAM geometry constants, burst limits and the per-port
//            read channel state encoding for the VPU SRAM read burst engine.
// Revision : 1.0 - initial release
// ============================================================================
package vpu_sram_rd_burst_engine_pkg;

  localparam int SRAM_R_PORT_CNT     = 3;
  localparam int SRAM_DATA_WIDTH     = 32;
  localparam int SRAM_BANK_CNT_LG2   = 3;
  localparam int SRAM_BANK_DEPTH_LG2 = 8;

  // Largest burst one command may request per port (power of two).
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_REQ   = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } rd_chan_state_t;

endpackage
`default_nettype wire

// File: rtl/vpu_sram_rd_chan.sv
`default_nettype none
// ============================================================================
// Module   : vpu_sram_rd_chan
// Purpose  : One SRAM read port. Requests its bank, issues len+1 read beats
//            while granted, counts returned data and flags unexpected returns.
// Revision : 1.0 - initial release
// Ports    : clk/rst        clock, synchronous active-high reset
//            start_i        load cfg_* and begin a burst (only honoured in idle)
//            cfg_rid_i      bank id          cfg_addr_i  base word address
//            cfg_len_i      beats minus one
//            ack_i          bank grant (level)
//            req_o/rid_o    bank request and bank id
//            addr_o         beat address     reb_o  active-low read strobe
//            rlast_o        final beat marker
//            rdata_i/rvalid_i   returned data
//            dout_valid_o/dout_data_o  registered return data
//            idle_next_o    channel will be idle next cycle
//            err_o          sticky: return data arrived when none was expected
// ============================================================================
module vpu_sram_rd_chan
  import vpu_sram_rd_burst_engine_pkg::*;
#(
  parameter int BANK_W = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [BANK_W-1:0] cfg_rid_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic              ack_i,
  output logic              req_o,
  output logic [BANK_W-1:0] rid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              reb_o,
  output logic              rlast_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rvalid_i,
  output logic              dout_valid_o,
  output logic [DATA_W-1:0] dout_data_o,
  output logic              idle_next_o,
  output logic              err_o
);

  rd_chan_state_t    state_q, state_d;
  logic [BANK_W-1:0] rid_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W:0]    ret_cnt_q, ret_cnt_d;
  logic              dout_valid_q;
  logic [DATA_W-1:0] dout_data_q;
  logic              err_q;

  logic              w_beat;
  logic              w_last_beat;
  logic [LEN_W:0]    w_ret_target;
  logic              w_ret_ok;
  logic              w_ret_bad;

  assign w_beat       = (state_q == RD_ISSUE) && ack_i;
  assign w_last_beat  = w_beat && (issue_cnt_q == len_q);
  assign w_ret_target = {1'b0, len_q} + 1'b1;
  // Returns may overlap the issue phase; anything past len+1 beats, or
  // arriving while no burst is outstanding, is dropped and flagged.
  assign w_ret_ok     = rvalid_i
                        && ((state_q == RD_ISSUE) || (state_q == RD_DRAIN))
                        && (ret_cnt_q != w_ret_target);
  assign w_ret_bad    = rvalid_i && !w_ret_ok;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    if (w_ret_ok) begin
      ret_cnt_d = ret_cnt_q + 1'b1;
    end
    case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          state_d     = RD_REQ;
          addr_d      = cfg_addr_i;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
      end
      RD_REQ: begin
        if (ack_i) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (w_beat) begin
          // Address wraps naturally modulo the bank depth.
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (w_last_beat) begin
            state_d = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (w_ret_ok && (ret_cnt_d == w_ret_target)) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      rid_q        <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      if (start_i && (state_q == RD_IDLE)) begin
        rid_q <= cfg_rid_i;
        len_q <= cfg_len_i;
      end
      dout_valid_q <= w_ret_ok;
      if (w_ret_ok) begin
        dout_data_q <= rdata_i;
      end
      if (w_ret_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign req_o        = (state_q == RD_REQ) || (state_q == RD_ISSUE);
  assign rid_o        = rid_q;
  assign addr_o       = addr_q;
  assign reb_o        = !w_beat;
  assign rlast_o      = w_last_beat;
  assign dout_valid_o = dout_valid_q;
  assign dout_data_o  = dout_data_q;
  assign idle_next_o  = (state_d == RD_IDLE);
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: rtl/vpu_sram_rd_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : vpu_sram_rd_burst_engine
// Purpose  : Multi-port SRAM read engine between VPU operand fetch and the
//            SRAM read ports. Accepts one command naming bank/base/length per
//            port, runs one burst per enabled port and pulses done when all
//            enabled ports have received their data.
// Revision : 1.0 - initial release
// Ports    : clk/rst                  clock, synchronous active-high reset
//            cmd_valid_i/cmd_ready_o  command handshake (ready == idle)
//            cmd_port_en_i            per-port enable
//            cmd_rid_i/cmd_addr_i     per-port bank id / base address
//            cmd_len_i                beats minus one, shared by all ports
//            req_o/ack_i/rid_o        per-port bank arbitration
//            addr_o/reb_o/rlast_o     per-port beat address, strobe (low), last
//            rdata_i/rvalid_i         per-port returned data
//            dout_valid_o/dout_data_o registered return data
//            busy_o/done_o/err_o      status
// ============================================================================
module vpu_sram_rd_burst_engine
  import vpu_sram_rd_burst_engine_pkg::*;
#(
  parameter int PORT_CNT  = SRAM_R_PORT_CNT,
  parameter int DATA_W    = SRAM_DATA_WIDTH,
  parameter int BANK_W    = SRAM_BANK_CNT_LG2,
  parameter int ADDR_W    = SRAM_BANK_DEPTH_LG2,
  parameter int MAX_BURST = vpu_sram_rd_burst_engine_pkg::MAX_BURST
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [PORT_CNT-1:0]          cmd_port_en_i,
  input  logic [PORT_CNT*BANK_W-1:0]   cmd_rid_i,
  input  logic [PORT_CNT*ADDR_W-1:0]   cmd_addr_i,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len_i,
  output logic [PORT_CNT-1:0]          req_o,
  input  logic [PORT_CNT-1:0]          ack_i,
  output logic [PORT_CNT*BANK_W-1:0]   rid_o,
  output logic [PORT_CNT*ADDR_W-1:0]   addr_o,
  output logic [PORT_CNT-1:0]          reb_o,
  output logic [PORT_CNT-1:0]          rlast_o,
  input  logic [PORT_CNT*DATA_W-1:0]   rdata_i,
  input  logic [PORT_CNT-1:0]          rvalid_i,
  output logic [PORT_CNT-1:0]          dout_valid_o,
  output logic [PORT_CNT*DATA_W-1:0]   dout_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int CMD_LEN_W = $clog2(MAX_BURST);

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                w_accept;
  logic [PORT_CNT-1:0] w_idle_next;
  logic [PORT_CNT-1:0] w_err;

  assign w_accept = cmd_valid_i && !busy_q;

  generate
    for (genvar g = 0; g < PORT_CNT; g++) begin : g_chan
      vpu_sram_rd_chan #(
        .BANK_W (BANK_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (CMD_LEN_W)
      ) u_chan (
        .clk          (clk),
        .rst          (rst),
        .start_i      (w_accept && cmd_port_en_i[g]),
        .cfg_rid_i    (cmd_rid_i[g*BANK_W +: BANK_W]),
        .cfg_addr_i   (cmd_addr_i[g*ADDR_W +: ADDR_W]),
        .cfg_len_i    (cmd_len_i),
        .ack_i        (ack_i[g]),
        .req_o        (req_o[g]),
        .rid_o        (rid_o[g*BANK_W +: BANK_W]),
        .addr_o       (addr_o[g*ADDR_W +: ADDR_W]),
        .reb_o        (reb_o[g]),
        .rlast_o      (rlast_o[g]),
        .rdata_i      (rdata_i[g*DATA_W +: DATA_W]),
        .rvalid_i     (rvalid_i[g]),
        .dout_valid_o (dout_valid_o[g]),
        .dout_data_o  (dout_data_o[g*DATA_W +: DATA_W]),
        .idle_next_o  (w_idle_next[g]),
        .err_o        (w_err[g])
      );
    end
  endgenerate

  // Disabled ports never leave idle, so "all ports idle next cycle" is the
  // same as "all enabled ports finished". An empty command completes at once.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    if (w_accept) begin
      busy_d = |cmd_port_en_i;
      done_d = ~|cmd_port_en_i;
    end else if (busy_q && (&w_idle_next)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign cmd_ready_o = !busy_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = |w_err;

endmodule
`default_nettype wire
